// File: rtl/dfm_pkg.sv
// dfm_pkg: shared types and default widths for the measurement sequencer.
package dfm_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, GATE = 2'd1, WAIT = 2'd2} ctrl_state_t;
    localparam int RESULT_W  = 64;
    localparam int GATE_W_DEF = 32;
    localparam int TMO_W_DEF  = 32;
    localparam int CNT_W_DEF  = 16;
endpackage

// File: rtl/dfm_dncnt.sv
// dfm_dncnt: loadable down-counter that holds at zero and flags it.
module dfm_dncnt #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] val_i,
    output logic         zero_o
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i)
            cnt <= '0;
        else
            cnt <= load_i ? val_i : (en_i && !zero_o) ? cnt - W'(1) : cnt;
    assign zero_o = cnt == '0;
endmodule

// File: rtl/measure_ctrl.sv
// measure_ctrl: gates the measure core for a programmed time and collects its result,
// single-shot or continuous, with a result timeout.
module measure_ctrl
    import dfm_pkg::*;
#(
    parameter int GATE_W = GATE_W_DEF,
    parameter int TMO_W  = TMO_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                start_i,
    input  logic                cont_i,
    input  logic                stop_i,
    input  logic [GATE_W-1:0]   gate_time_i,
    input  logic [TMO_W-1:0]    timeout_i,
    output logic                gate_en_o,
    input  logic                meas_wr_en_i,
    input  logic [RESULT_W-1:0] meas_wr_data_i,
    input  logic                gate_sync_i,
    output logic [RESULT_W-1:0] result_o,
    output logic                result_valid_o,
    output logic                busy_o,
    output logic                gate_active_o,
    output logic                timeout_o,
    output logic                cfg_err_o,
    output logic [CNT_W-1:0]    meas_cnt_o
);
    ctrl_state_t      state;
    logic [TMO_W-1:0] tmo_q;
    logic             cont_q;
    logic             gate_zero, tmo_zero;
    logic             gt_ok, done, rearm, gate_load, tmo_load;

    assign gt_ok     = gate_time_i != '0;
    // A result on the expiry cycle counts as a result, not a timeout.
    assign done      = state == WAIT && (meas_wr_en_i || tmo_zero);
    assign rearm     = done && cont_q && !stop_i;
    assign gate_load = gt_ok && ((state == IDLE && start_i) || rearm);
    assign tmo_load  = state == GATE && gate_zero;
    assign gate_en_o = state == GATE;
    assign busy_o    = state != IDLE;

    // Loaded with N-1 so the zero flag marks the last of N gate cycles.
    dfm_dncnt #(.W(GATE_W)) u_gate_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .load_i  (gate_load),
        .en_i    (state == GATE),
        .val_i   (gate_time_i - GATE_W'(1)),
        .zero_o  (gate_zero)
    );

    dfm_dncnt #(.W(TMO_W)) u_tmo_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .load_i  (tmo_load),
        .en_i    (state == WAIT),
        .val_i   (tmo_q),
        .zero_o  (tmo_zero)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state          <= IDLE;
            tmo_q          <= '0;
            cont_q         <= 1'b0;
            result_o       <= '0;
            result_valid_o <= 1'b0;
            gate_active_o  <= 1'b0;
            timeout_o      <= 1'b0;
            cfg_err_o      <= 1'b0;
            meas_cnt_o     <= '0;
        end else begin
            result_valid_o <= state == WAIT && meas_wr_en_i;
            gate_active_o  <= gate_sync_i;
            if (state == IDLE && start_i) begin
                cfg_err_o <= !gt_ok;
                if (gt_ok)
                    timeout_o <= 1'b0;
            end
            if (state != IDLE && stop_i)
                cont_q <= 1'b0;
            if (tmo_load)
                state <= WAIT;
            if (state == WAIT && meas_wr_en_i) begin
                result_o   <= meas_wr_data_i;
                meas_cnt_o <= meas_cnt_o + CNT_W'(1);
            end
            if (done && !meas_wr_en_i)
                timeout_o <= 1'b1;
            if (done && !gate_load) begin
                state  <= IDLE;
                cont_q <= 1'b0;
                if (rearm)
                    cfg_err_o <= 1'b1;
            end
            if (gate_load) begin
                state  <= GATE;
                tmo_q  <= timeout_i;
                cont_q <= cont_i && !stop_i;
            end
        end
    end
endmodule

// File: tb/tb_measure_ctrl.sv
// tb_measure_ctrl: directed checks of measure_ctrl sequencing, timeout and error handling.
module tb_measure_ctrl;
    logic        clk = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        start_i = 1'b0, cont_i = 1'b0, stop_i = 1'b0;
    logic [31:0] gate_time_i = '0, timeout_i = '0;
    logic        gate_en_o;
    logic        meas_wr_en_i = 1'b0;
    logic [63:0] meas_wr_data_i = '0;
    logic        gate_sync_i = 1'b0;
    logic [63:0] result_o;
    logic        result_valid_o, busy_o, gate_active_o, timeout_o, cfg_err_o;
    logic [15:0] meas_cnt_o;

    int compared = 0, mismatched = 0;
    int rv_cnt = 0, rises = 0;
    logic gprev = 1'b0;
    int hi, rv0, ri0;

    measure_ctrl dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .start_i(start_i), .cont_i(cont_i), .stop_i(stop_i),
        .gate_time_i(gate_time_i), .timeout_i(timeout_i), .gate_en_o(gate_en_o),
        .meas_wr_en_i(meas_wr_en_i), .meas_wr_data_i(meas_wr_data_i), .gate_sync_i(gate_sync_i),
        .result_o(result_o), .result_valid_o(result_valid_o), .busy_o(busy_o),
        .gate_active_o(gate_active_o), .timeout_o(timeout_o), .cfg_err_o(cfg_err_o),
        .meas_cnt_o(meas_cnt_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (result_valid_o) rv_cnt++;
        if (gate_en_o && !gprev) rises++;
        gprev = gate_en_o;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input logic [31:0] gt, input logic [31:0] tmo, input logic c);
        gate_time_i = gt; timeout_i = tmo; cont_i = c; start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Counts gate-high cycles until the gate drops; raises stop_i on gate cycle stop_at.
    task automatic gate_len(output int n, input int stop_at);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            if (gate_en_o) begin
                n++;
                stop_i = (n == stop_at);
            end else if (n > 0) break;
            tick();
        end
        stop_i = 1'b0;
    endtask

    task automatic pulse_wr(input logic [63:0] d);
        meas_wr_data_i = d; meas_wr_en_i = 1'b1;
        tick();
        meas_wr_en_i = 1'b0;
    endtask

    initial begin
        tick(2);
        chk("rst_gate", gate_en_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_flags", {timeout_o, cfg_err_o, result_valid_o, gate_active_o}, 0);
        chk("rst_cnt", meas_cnt_o, 0);
        rst_n_i = 1'b1;
        tick(2);
        gate_sync_i = 1'b1;
        tick();
        chk("gate_active", gate_active_o, 1);
        gate_sync_i = 1'b0;

        // Single shot: 100-cycle gate, result 20 cycles after close
        rv0 = rv_cnt;
        pulse_start(100, 1000, 0);
        chk("ss_busy", busy_o, 1);
        gate_len(hi, 0);
        chk("ss_gate_len", hi, 100);
        tick(20);
        pulse_wr(64'h0000_0010_0000_03E8);
        chk("ss_valid", result_valid_o, 1);
        chk("ss_result", result_o, 64'h0000_0010_0000_03E8);
        chk("ss_cnt", meas_cnt_o, 1);
        chk("ss_idle", busy_o, 0);
        tick();
        chk("ss_valid_pulse", result_valid_o, 0);
        chk("ss_rv_count", rv_cnt - rv0, 1);

        // Continuous: three 50-cycle gates, stop raised during the third
        rv0 = rv_cnt; ri0 = rises;
        pulse_start(50, 1000, 1);
        for (int k = 0; k < 3; k++) begin
            gate_len(hi, (k == 2) ? 10 : 0);
            chk("cm_gate_len", hi, 50);
            tick(5);
            pulse_wr(64'h100 + 64'(k));
            chk("cm_result", result_o, 64'h100 + 64'(k));
            chk("cm_rearm", gate_en_o, (k < 2) ? 1 : 0);
        end
        tick(20);
        chk("cm_idle", busy_o, 0);
        chk("cm_results", rv_cnt - rv0, 3);
        chk("cm_gates", rises - ri0, 3);
        chk("cm_cnt", meas_cnt_o, 4);

        // Timeout: 200-cycle window with no result
        rv0 = rv_cnt;
        pulse_start(10, 200, 0);
        gate_len(hi, 0);
        chk("to_gate_len", hi, 10);
        tick(200);
        chk("to_not_yet", timeout_o, 0);
        chk("to_busy", busy_o, 1);
        tick();
        chk("to_flag", timeout_o, 1);
        chk("to_idle", busy_o, 0);
        chk("to_no_result", rv_cnt - rv0, 0);

        // Accepted start clears timeout; result on the exact expiry cycle wins
        pulse_start(10, 3, 0);
        chk("to_cleared", timeout_o, 0);
        gate_len(hi, 0);
        tick(3);
        pulse_wr(64'hABCD_0000_1234_5678);
        chk("edge_valid", result_valid_o, 1);
        chk("edge_result", result_o, 64'hABCD_0000_1234_5678);
        chk("edge_no_to", timeout_o, 0);
        chk("edge_cnt", meas_cnt_o, 5);

        // Config error, then a stray write in IDLE
        pulse_start(0, 100, 0);
        chk("cfg_err", cfg_err_o, 1);
        chk("cfg_gate", gate_en_o, 0);
        chk("cfg_busy", busy_o, 0);
        rv0 = rv_cnt;
        pulse_wr(64'hDEAD_BEEF_DEAD_BEEF);
        tick();
        chk("stray_result", result_o, 64'hABCD_0000_1234_5678);
        chk("stray_cnt", meas_cnt_o, 5);
        chk("stray_valid", rv_cnt - rv0, 0);

        // Reset at gate cycle 30 of 100
        pulse_start(100, 1000, 0);
        chk("cfg_cleared", cfg_err_o, 0);
        tick(29);
        chk("mid_gate", gate_en_o, 1);
        rst_n_i = 1'b0;
        #1;
        chk("arst_gate", gate_en_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_result", result_o, 0);
        chk("arst_cnt", meas_cnt_o, 0);
        tick(2);
        rst_n_i = 1'b1;
        ri0 = rises;
        tick(10);
        chk("post_rst_idle", busy_o, 0);
        chk("post_rst_gates", rises - ri0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
